// File: rtl/switch_debouncer.sv
// Two-channel switch/button conditioner feeding the lab AND-gate stage.
// Each channel synchronizes a raw, bouncy input through two flops, then
// accepts a new level only after the synchronized value has held for
// STABLE_CYCLES consecutive cycles past the first transition sample.
// Registered level plus single-cycle rise/fall pulses are produced per
// channel. STABLE_CYCLES must lie in 2 .. 2**CNT_W-1.

module debounce_channel #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Final count value of a qualifying window; reaching it while the
  // synchronized input still agrees commits the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;

  // Two-flop synchronizer: raw is asynchronous, only s2 reaches the FSM.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse s1 and s2
  // into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // State, counter and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic: qualify a transition window, abort on any bounce.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch; pulses default to 0 so they
  // last exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (s2) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          // Bounce: drop the window without touching the outputs.
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!s2) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
      end
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

module switch_debouncer #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_a,
  input  logic raw_b,
  output logic input_a,
  output logic input_b,
  output logic rise_a,
  output logic rise_b,
  output logic fall_a,
  output logic fall_b
);

  // Channel A: drives gate operand A.
  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_a),
    .level (input_a),
    .rise  (rise_a),
    .fall  (fall_a)
  );

  // Channel B: drives gate operand B; shares nothing with channel A.
  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_b),
    .level (input_b),
    .rise  (rise_b),
    .fall  (fall_b)
  );

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (STABLE_CYCLES=4, CNT_W=3).
// Reference model: a channel's level flips once the synchronized input has
// disagreed with it on the last STABLE_CYCLES+1 consecutive samples taken
// since the previous flip or reset. Directed scenarios followed by random
// bouncy stimulus; every cycle is compared against the model.

module tb_switch_debouncer;

  localparam int N     = 4;
  localparam int CNT_W = 3;
  localparam int HMAX  = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic input_a, input_b, rise_a, rise_b, fall_a, fall_b;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state.
  int edge_no = 0;
  bit pipe    [2][2];
  bit hist    [2][HMAX];
  int since   [2];
  bit exp_lvl [2];
  bit exp_rise[2];
  bit exp_fall[2];

  switch_debouncer #(
    .STABLE_CYCLES (N),
    .CNT_W         (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .raw_a   (raw_a),
    .raw_b   (raw_b),
    .input_a (input_a),
    .input_b (input_b),
    .rise_a  (rise_a),
    .rise_b  (rise_b),
    .fall_a  (fall_a),
    .fall_b  (fall_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, want, edge_no);
    end
  endtask

  // Advance the model of one channel by one clock edge.
  task automatic model_edge(input int ch, input bit r, input bit raw);
    bit s2;
    bit agree;
    exp_rise[ch] = 1'b0;
    exp_fall[ch] = 1'b0;
    if (r) begin
      pipe[ch][0] = 1'b0;
      pipe[ch][1] = 1'b0;
      exp_lvl[ch] = 1'b0;
      since[ch]   = edge_no + 1;
    end else begin
      s2          = pipe[ch][1];
      pipe[ch][1] = pipe[ch][0];
      pipe[ch][0] = raw;
      hist[ch][edge_no] = s2;
      if (edge_no - since[ch] + 1 >= N + 1) begin
        agree = 1'b1;
        for (int k = edge_no - N; k <= edge_no; k++)
          if (hist[ch][k] == exp_lvl[ch]) agree = 1'b0;
        if (agree) begin
          exp_lvl[ch] = !exp_lvl[ch];
          if (exp_lvl[ch]) exp_rise[ch] = 1'b1;
          else             exp_fall[ch] = 1'b1;
          since[ch] = edge_no + 1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, update the model, compare all outputs.
  task automatic step(input logic r, input logic ra, input logic rb);
    @(negedge clk);
    rst   = r;
    raw_a = ra;
    raw_b = rb;
    @(posedge clk);
    edge_no++;
    model_edge(0, r, ra);
    model_edge(1, r, rb);
    #1;
    check("input_a", input_a, exp_lvl[0]);
    check("input_b", input_b, exp_lvl[1]);
    check("rise_a",  rise_a,  exp_rise[0]);
    check("rise_b",  rise_b,  exp_rise[1]);
    check("fall_a",  fall_a,  exp_fall[0]);
    check("fall_b",  fall_b,  exp_fall[1]);
  endtask

  initial begin
    int first;
    int first_b;
    int n_r;
    int n_x;
    int hold_a;
    int hold_b;
    bit ra;
    bit rb;
    bit rr;
    bit pat [8];

    // 1. Clean rise on channel A.
    repeat (2) step(1'b1, 1'b0, 1'b0);
    check("reset_input_a", input_a, 1'b0);
    first = 0; first_b = 0; n_r = 0;
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 1'b1, 1'b0);
      if (input_a && first == 0) first = e;
      if (rise_a) begin n_r++; first_b = e; end
    end
    check("s1_rise_edge", first, 7);
    check("s1_rise_pulse_edge", first_b, 7);
    check("s1_rise_pulses", n_r, 1);

    // 2. Bounce rejection: the 0 restarts the window.
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    repeat (2) step(1'b1, 1'b0, 1'b0);
    first = 0; n_r = 0;
    for (int e = 1; e <= 14; e++) begin
      step(1'b0, (e <= 8) ? pat[e-1] : 1'b1, 1'b0);
      if (input_a && first == 0) first = e;
      if (rise_a) n_r++;
    end
    check("s2_rise_edge", first, 10);
    check("s2_rise_pulses", n_r, 1);

    // 3. Short glitch on channel B never qualifies.
    repeat (2) step(1'b1, 1'b0, 1'b0);
    n_x = 0;
    for (int e = 1; e <= 14; e++) begin
      step(1'b0, 1'b0, e <= 3);
      if (input_b || rise_b || fall_b) n_x++;
    end
    check("s3_glitch_activity", n_x, 0);

    // 4. Both channels high, then both fall together.
    repeat (2) step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b1);
    check("s4_both_high", {input_a, input_b}, 2'b11);
    first = 0; first_b = 0;
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 1'b0, 1'b0);
      if (fall_a) first = e;
      if (fall_b) first_b = e;
    end
    check("s4_fall_a_edge", first, 7);
    check("s4_fall_b_edge", first_b, 7);

    // 5. Reset mid-window, then reset while high.
    repeat (2) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    n_x = 0;
    repeat (2) begin
      step(1'b1, 1'b1, 1'b0);
      if (input_a || rise_a) n_x++;
    end
    check("s5_quiet_in_reset", n_x, 0);
    first = 0; n_r = 0;
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 1'b1, 1'b0);
      if (input_a && first == 0) first = e;
      if (rise_a) n_r++;
    end
    check("s5_rerise_edge", first, 7);
    check("s5_rerise_pulses", n_r, 1);
    step(1'b1, 1'b1, 1'b0);
    check("s5_rst_drop_level", input_a, 1'b0);
    check("s5_rst_no_fall", fall_a, 1'b0);
    repeat (8) step(1'b0, 1'b1, 1'b0);

    // 6. AND gate hookup: result high only once both qualify.
    repeat (2) step(1'b1, 1'b0, 1'b0);
    first = 0;
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 1'b1, 1'b1);
      check("s6_gate", input_a & input_b, exp_lvl[0] & exp_lvl[1]);
      if ((input_a & input_b) && first == 0) first = e;
    end
    check("s6_gate_rise_edge", first, 7);
    first = 0;
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 1'b1, 1'b0);
      if (!(input_a & input_b) && first == 0) first = e;
    end
    check("s6_gate_fall_edge", first, 7);

    // Random bouncy stimulus with occasional resets.
    ra = 1'b0; rb = 1'b0;
    hold_a = 1; hold_b = 1;
    for (int c = 0; c < 2000; c++) begin
      if (--hold_a == 0) begin
        ra = $urandom_range(0, 1);
        hold_a = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 6);
      end
      if (--hold_b == 0) begin
        rb = $urandom_range(0, 1);
        hold_b = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 6);
      end
      rr = ($urandom_range(0, 149) == 0);
      step(rr, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Two-channel input conditioner placed directly upstream of the lab's two-input AND gate stage.
- Takes raw board slide switches or push buttons (asynchronous, bouncy) and produces clean, synchronous levels that drive the gate's two operand inputs.
- Also produces single-cycle rise/fall pulses per channel for later counter and LED labs.
- Both channels are identical and independent.

Parameters:
- STABLE_CYCLES, 1000000, consecutive cycles the synchronized input must hold a new value before the output changes (10 ms at 100 MHz). Legal range 2 .. 2^CNT_W-1.
- CNT_W, 20, width of each channel's stability counter.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- raw_a  input  1  bouncy, asynchronous switch input, channel A
- raw_b  input  1  bouncy, asynchronous switch input, channel B
- input_a  output  1  debounced level, channel A (drives gate operand A)
- input_b  output  1  debounced level, channel B (drives gate operand B)
- rise_a  output  1  one-cycle pulse when input_a goes 0->1
- rise_b  output  1  one-cycle pulse when input_b goes 0->1
- fall_a  output  1  one-cycle pulse when input_a goes 1->0
- fall_b  output  1  one-cycle pulse when input_b goes 1->0

Behaviour:
- Clocking and reset: one clock domain, synchronous active-high reset.
- Reset values: both synchronizer flops = 0, cnt = 0, state = IDLE_LOW, and input_a, input_b, rise_*, fall_* all = 0. Every output is registered.
- Synchronizer: per channel, two flops in series, raw -> s1 -> s2. Only s2 feeds the FSM. Raw inputs are never used combinationally.
- FSM states, per channel: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - IDLE_LOW: if s2=1, go to WAIT_HIGH with cnt<=0. Otherwise stay.
  - WAIT_HIGH:
    - if s2=0, return to IDLE_LOW (bounce rejected; no output change, no pulse);
    - else if cnt=STABLE_CYCLES-1, go to IDLE_HIGH with level<=1 and rise<=1;
    - else cnt<=cnt+1.
  - IDLE_HIGH and WAIT_LOW: mirror of the above with polarity inverted. The fall pulse is issued on entry to IDLE_LOW from WAIT_LOW.
- Pulses: rise/fall are high for exactly one cycle, in the same cycle the level output first shows its new value. Otherwise 0.
- Latency: call the first edge that samples the new raw value edge 1. The level output changes after edge STABLE_CYCLES+3. Example: STABLE_CYCLES=4 gives edge 7.
- Bounce inside the window: any opposite sample in s2 during WAIT_* aborts the window. The count restarts from 0 on the next qualifying transition. There is no partial credit.
- Counter: saturates never, because it is bounded by the exit at STABLE_CYCLES-1. It is only meaningful in WAIT_* states and holds its value elsewhere.
- Simultaneous events: channels A and B share nothing. Both may pulse in the same cycle.
- Reset mid-operation: rst=1 in any state forces reset values on that edge, including discarding a partially counted window and dropping a high level to 0 without a fall pulse. If raw is held high through reset release, the channel re-qualifies with full latency and issues one rise pulse.
- rst has priority over every other condition.

Test Plan:
(sim with STABLE_CYCLES=4, CNT_W=3)
1. Clean rise: rst 2 cycles, then raw_a 0->1 held -> input_a=1 after edge 7; rise_a=1 for exactly that cycle; fall_a, input_b, rise_b stay 0.
2. Bounce rejection: raw_a pattern 1,1,0,1,1,1,1,1 per cycle -> the 0 aborts the first window; input_a rises 7 edges after the last 0->1; exactly one rise_a pulse.
3. Short glitch: raw_b high for 3 cycles, then low -> input_b, rise_b, fall_b remain 0 throughout.
4. Clean fall and both channels together: both qualified high, then raw_a and raw_b drop on the same edge -> input_a and input_b fall on the same edge 7; fall_a and fall_b pulse in the same cycle.
5. Reset mid-operation:
   - rst mid-window, raw_a held 1 -> no output change during reset;
   - after release, input_a rises 7 edges after the first post-reset edge, with one rise_a;
   - rst while input_a=1 -> input_a=0 next edge with fall_a=0.
6. Gate hookup: instantiate with the AND gate, hold raw_a=raw_b=1 -> gate result=1 only after both channels qualify; drop raw_b -> result=0 on edge 7.
